// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution MAC: derived widths, frame FSM states
// and the lane slice helper.
package conv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } frame_state_t;

  function automatic int prod_w(input int dw, input int cw);
    return dw + cw + 1;
  endfunction

  // Nine products plus four bits of growth; the full-scale sum cannot overflow.
  function automatic int acc_w(input int dw, input int cw);
    return dw + cw + 5;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/conv3x3_mac_if.sv
// Window-in / pixel-out stream bundle with its EOL/tlast sideband.
interface conv3x3_mac_if #(
  parameter int DATA_WIDTH = 8
);
  logic [9*DATA_WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_eol;
  logic                    s_tlast;
  logic [DATA_WIDTH-1:0]   m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_eol;
  logic                    m_tlast;

  modport master (
    output s_data, s_valid, s_eol, s_tlast, m_ready,
    input  s_ready, m_data, m_valid, m_eol, m_tlast
  );

  modport slave (
    input  s_data, s_valid, s_eol, s_tlast, m_ready,
    output s_ready, m_data, m_valid, m_eol, m_tlast
  );
endinterface

// File: rtl/conv_pipe_stage.sv
// Generic valid/ready register slice; loads whenever it is empty or its content
// moves on, so bubbles collapse and a full chain still streams one beat per cycle.
module conv_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_load;

  assign w_load = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_ready = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/conv3x3_mac.sv
// Signed 9-tap MAC over a 3x3 window: multiply, row sums, final sum with rounding,
// shift and unsigned saturation, one register slice per step.
//   state | meaning
//   IDLE  | between frames; coefficients track the coef input every cycle
//   RUN   | inside a frame; coefficients frozen until the tlast beat is accepted
module conv3x3_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int SHIFT      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  conv3x3_mac_if.slave            bus,
  input  logic [9*COEF_WIDTH-1:0] coef,
  output logic                    busy
);
  localparam int PROD_W  = prod_w(DATA_WIDTH, COEF_WIDTH);
  localparam int ACC_W   = acc_w(DATA_WIDTH, COEF_WIDTH);
  localparam int S1_W    = 9*PROD_W + 2;
  localparam int S2_W    = 3*ACC_W + 2;
  localparam int S3_W    = DATA_WIDTH + 2;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W-1:0] RND = (SHIFT > 0) ? (ACC_W'(1) << RND_POS) : '0;

  frame_state_t            r_state, w_state_nxt;
  logic [9*COEF_WIDTH-1:0] r_coef;
  logic                    w_s_fire;

  assign w_s_fire = bus.s_valid & bus.s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_coef  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) r_coef <= coef;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_s_fire && !bus.s_tlast) w_state_nxt = RUN;
      RUN:     if (w_s_fire && bus.s_tlast)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  logic [9*PROD_W-1:0] w_prod;

  for (genvar i = 0; i < 9; i++) begin : g_tap
    logic [DATA_WIDTH-1:0]    w_pix;
    logic [COEF_WIDTH-1:0]    w_k;
    logic signed [PROD_W-1:0] w_pix_x, w_k_x;
    assign w_pix   = bus.s_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
    assign w_k     = r_coef[slice_lo(i, COEF_WIDTH) +: COEF_WIDTH];
    assign w_pix_x = {{(PROD_W-DATA_WIDTH){1'b0}}, w_pix};
    assign w_k_x   = {{(PROD_W-COEF_WIDTH){w_k[COEF_WIDTH-1]}}, w_k};
    assign w_prod[slice_lo(i, PROD_W) +: PROD_W] = w_pix_x * w_k_x;
  end

  logic              w_v1, w_v2, w_v3;
  logic              w_rdy1, w_rdy2, w_rdy3;
  logic [S1_W-1:0]   w_s1_q;
  logic [S2_W-1:0]   w_s2_q;
  logic [S3_W-1:0]   w_s3_q;
  logic [3*ACC_W-1:0] w_rows;

  // Sideband rides in the top two bits of every slice: {eol, tlast, payload}.
  conv_pipe_stage #(.WIDTH(S1_W)) u_s1 (
    .clk(clk), .rst(rst),
    .i_valid(bus.s_valid), .o_ready(w_rdy1),
    .i_data({bus.s_eol, bus.s_tlast, w_prod}),
    .o_valid(w_v1), .i_ready(w_rdy2), .o_data(w_s1_q)
  );

  for (genvar r = 0; r < 3; r++) begin : g_row
    logic [2:0][ACC_W-1:0] w_ext;
    for (genvar j = 0; j < 3; j++) begin : g_col
      assign w_ext[j] = {{(ACC_W-PROD_W){w_s1_q[(3*r+j+1)*PROD_W-1]}},
                         w_s1_q[(3*r+j)*PROD_W +: PROD_W]};
    end
    assign w_rows[r*ACC_W +: ACC_W] = w_ext[0] + w_ext[1] + w_ext[2];
  end

  conv_pipe_stage #(.WIDTH(S2_W)) u_s2 (
    .clk(clk), .rst(rst),
    .i_valid(w_v1), .o_ready(w_rdy2),
    .i_data({w_s1_q[S1_W-1 -: 2], w_rows}),
    .o_valid(w_v2), .i_ready(w_rdy3), .o_data(w_s2_q)
  );

  logic [ACC_W-1:0]        w_sum, w_rnd;
  logic signed [ACC_W-1:0] w_shr;
  logic [DATA_WIDTH-1:0]   w_pix_sat;

  assign w_sum = w_s2_q[0 +: ACC_W] + w_s2_q[ACC_W +: ACC_W] + w_s2_q[2*ACC_W +: ACC_W];
  assign w_rnd = w_sum + RND;
  assign w_shr = $signed(w_rnd) >>> SHIFT;

  always_comb begin
    w_pix_sat = w_shr[DATA_WIDTH-1:0];
    if (w_shr[ACC_W-1])                     w_pix_sat = '0;
    else if (|w_shr[ACC_W-2:DATA_WIDTH])    w_pix_sat = '1;
  end

  conv_pipe_stage #(.WIDTH(S3_W)) u_s3 (
    .clk(clk), .rst(rst),
    .i_valid(w_v2), .o_ready(w_rdy3),
    .i_data({w_s2_q[S2_W-1 -: 2], w_pix_sat}),
    .o_valid(w_v3), .i_ready(bus.m_ready), .o_data(w_s3_q)
  );

  assign bus.s_ready = w_rdy1;
  assign bus.m_valid = w_v3;
  assign bus.m_data  = w_s3_q[DATA_WIDTH-1:0];
  assign bus.m_tlast = w_s3_q[DATA_WIDTH];
  assign bus.m_eol   = w_s3_q[DATA_WIDTH+1];
  assign busy        = (r_state == RUN) | w_v1 | w_v2 | w_v3;
endmodule
